// File: rtl/sparc_mem_pkg.sv
// Purpose: shared op3 codes, FSM states and access-size decode for the SPARC RAM responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sparc_mem_pkg;

  // SPARC op3 values understood by the responder
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // SZ_NONE marks an op3 the responder does not implement
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  typedef struct packed {
    size_e size;
    logic  sgn;    // sign-extend the load result
    logic  store;  // write access
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d.size  = SZ_NONE;
    d.sgn   = 1'b0;
    d.store = 1'b0;
    case (op)
      OP_LD:   d.size = SZ_WORD;
      OP_LDUB: d.size = SZ_BYTE;
      OP_LDUH: d.size = SZ_HALF;
      OP_LDSB: begin d.size = SZ_BYTE; d.sgn = 1'b1; end
      OP_LDSH: begin d.size = SZ_HALF; d.sgn = 1'b1; end
      OP_ST:   begin d.size = SZ_WORD; d.store = 1'b1; end
      OP_STB:  begin d.size = SZ_BYTE; d.store = 1'b1; end
      OP_STH:  begin d.size = SZ_HALF; d.store = 1'b1; end
      default: d.size = SZ_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Purpose: control-unit <-> RAM load/store handshake bundle (request, data, MFC/MSET).
// Latency: n/a (wires only); master = control unit, slave = responder.
// Backpressure: four-phase; RAM_enable held until MFC or MSET, then dropped for a cycle.
interface ram_responder_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  RAM_enable;
  logic [5:0]            RAM_OpCode;
  logic [ADDR_WIDTH-1:0] Address;
  logic [31:0]           DataIn;
  logic [31:0]           DataOut;
  logic                  MFC;
  logic                  MSET;

  modport master (
    output RAM_enable, RAM_OpCode, Address, DataIn,
    input  DataOut, MFC, MSET
  );

  modport slave (
    input  RAM_enable, RAM_OpCode, Address, DataIn,
    output DataOut, MFC, MSET
  );
endinterface

// File: rtl/ram_byte_array.sv
// Purpose: 2**ADDR_WIDTH x 8 storage, 4-lane byte write, 4-byte big-endian read at addr_i.
// Latency: combinational read, write on rising clk_i; no reset (contents survive reset).
// Backpressure: none; ports: clk_i, addr_i (base), we_i (lane 3 = Mem[a]), wdat_i, rdat_o.
module ram_byte_array #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            we_i,
  input  logic [31:0]           wdat_i,
  output logic [31:0]           rdat_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr1, addr2, addr3;

  // Lanes past the top wrap; only unused lanes of narrow accesses can get there.
  assign addr1 = addr_i + ADDR_WIDTH'(1);
  assign addr2 = addr_i + ADDR_WIDTH'(2);
  assign addr3 = addr_i + ADDR_WIDTH'(3);

  assign rdat_o = {mem_q[addr_i], mem_q[addr1], mem_q[addr2], mem_q[addr3]};

  always_ff @(posedge clk_i) begin
    if (we_i[3]) mem_q[addr_i] <= wdat_i[31:24];
    if (we_i[2]) mem_q[addr1]  <= wdat_i[23:16];
    if (we_i[1]) mem_q[addr2]  <= wdat_i[15:8];
    if (we_i[0]) mem_q[addr3]  <= wdat_i[7:0];
  end
endmodule

// File: rtl/ram_responder.sv
// Purpose: big-endian byte-addressed RAM answering SPARC load/store requests with MFC or MSET.
// Latency: request accepted at edge k -> MFC/MSET high after edge k+1+WAIT_CYCLES.
// Backpressure: four-phase; result held while RAM_enable high, IDLE after it drops.
// Ports: Clk, RESET (sync, active high), bus (slave side of ram_responder_if).
module ram_responder
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           Clk,
  input  logic           RESET,
  ram_responder_if.slave bus
);
  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [5:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           dout_q, dout_d;
  logic                  mfc_q, mfc_d;
  logic                  mset_q, mset_d;

  op_dec_t               dec;
  logic                  aligned;
  logic [31:0]           load_val;
  logic [31:0]           mem_wdat, mem_rdat;
  logic [3:0]            lane_we, mem_we;

  // Decode from the latched request so later bus changes cannot disturb it.
  assign dec = decode_op(op_q);

  ram_byte_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk_i  (Clk),
    .addr_i (addr_q),
    .we_i   (mem_we),
    .wdat_i (mem_wdat),
    .rdat_o (mem_rdat)
  );

  // Alignment, load extension and store lane placement; narrow data sits in the top lanes.
  always_comb begin
    aligned  = 1'b1;
    load_val = mem_rdat;
    mem_wdat = din_q;
    lane_we  = 4'b1111;
    case (dec.size)
      SZ_BYTE: begin
        load_val = {{24{dec.sgn & mem_rdat[31]}}, mem_rdat[31:24]};
        mem_wdat = {din_q[7:0], 24'h0};
        lane_we  = 4'b1000;
      end
      SZ_HALF: begin
        aligned  = ~addr_q[0];
        load_val = {{16{dec.sgn & mem_rdat[31]}}, mem_rdat[31:16]};
        mem_wdat = {din_q[15:0], 16'h0};
        lane_we  = 4'b1100;
      end
      SZ_WORD: aligned = (addr_q[1:0] == 2'b00);
      default: lane_we = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mset_d  = mset_q;
    mem_we  = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (bus.RAM_enable) begin
          op_d    = bus.RAM_OpCode;
          addr_d  = bus.Address;
          din_d   = bus.DataIn;
          cnt_d   = 4'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LIMIT) begin
          state_d = S_DONE;
          if (dec.size == SZ_NONE || !aligned) begin
            mset_d = 1'b1;
          end else begin
            mfc_d = 1'b1;
            // A reset landing on the completion edge must abandon the write too.
            if (dec.store) mem_we = lane_we & {4{~RESET}};
            else           dout_d = load_val;
          end
        end
      end
      S_DONE: begin
        if (!bus.RAM_enable) begin
          state_d = S_IDLE;
          mfc_d   = 1'b0;
          mset_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'h0;
      mfc_q   <= 1'b0;
      mset_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mset_q  <= mset_d;
    end
    op_q   <= op_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  assign bus.DataOut = dout_q;
  assign bus.MFC     = mfc_q;
  assign bus.MSET    = mset_q;
endmodule

// File: tb/tb_ram_responder.sv
// Purpose: self-checking bench for ram_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Latency: expected results queued at request time, compared when MFC/MSET appears.
// Backpressure: four-phase handshake driven by the bench as the control unit.
module tb_ram_responder;
  import sparc_mem_pkg::*;

  localparam logic [5:0] C_LD   = 6'b000000;
  localparam logic [5:0] C_LDUB = 6'b000001;
  localparam logic [5:0] C_LDUH = 6'b000010;
  localparam logic [5:0] C_ST   = 6'b000100;
  localparam logic [5:0] C_STB  = 6'b000101;
  localparam logic [5:0] C_STH  = 6'b000110;
  localparam logic [5:0] C_LDSB = 6'b001001;
  localparam logic [5:0] C_LDSH = 6'b001010;
  localparam logic [5:0] C_BAD  = 6'b001111;

  typedef struct packed {
    logic        mfc;
    logic        mset;
    logic [31:0] dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [7:0]  model_mem [0:1][0:511];
  logic [31:0] model_dout [0:1];

  always #5 clk = ~clk;

  ram_responder_if #(.ADDR_WIDTH(9)) bus0 ();
  ram_responder_if #(.ADDR_WIDTH(9)) bus1 ();

  ram_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) u_dut0 (.Clk(clk), .RESET(rst), .bus(bus0));
  ram_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_dut1 (.Clk(clk), .RESET(rst), .bus(bus1));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_lat(input int sel);
    return (sel == 0) ? 4 : 2;
  endfunction

  function automatic logic rd_mfc(input int sel);
    return (sel == 0) ? bus0.MFC : bus1.MFC;
  endfunction

  function automatic logic rd_mset(input int sel);
    return (sel == 0) ? bus0.MSET : bus1.MSET;
  endfunction

  function automatic logic [31:0] rd_dout(input int sel);
    return (sel == 0) ? bus0.DataOut : bus1.DataOut;
  endfunction

  // Reference model: updates the model memory/DataOut and returns the expected response.
  function automatic exp_t predict(input int sel, input logic [5:0] op,
                                   input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    logic bad;
    logic [7:0] b0, b1, b2, b3;
    int ai;
    ai  = int'(a);
    b0  = model_mem[sel][ai];
    b1  = model_mem[sel][(ai + 1) % 512];
    b2  = model_mem[sel][(ai + 2) % 512];
    b3  = model_mem[sel][(ai + 3) % 512];
    bad = 1'b0;
    case (op)
      C_LD:   if (a[1:0] == 2'b00) model_dout[sel] = {b0, b1, b2, b3}; else bad = 1'b1;
      C_LDUB: model_dout[sel] = {24'h0, b0};
      C_LDSB: model_dout[sel] = {{24{b0[7]}}, b0};
      C_LDUH: if (!a[0]) model_dout[sel] = {16'h0, b0, b1}; else bad = 1'b1;
      C_LDSH: if (!a[0]) model_dout[sel] = {{16{b0[7]}}, b0, b1}; else bad = 1'b1;
      C_ST: begin
        if (a[1:0] == 2'b00) begin
          model_mem[sel][ai]     = d[31:24];
          model_mem[sel][ai + 1] = d[23:16];
          model_mem[sel][ai + 2] = d[15:8];
          model_mem[sel][ai + 3] = d[7:0];
        end else bad = 1'b1;
      end
      C_STH: begin
        if (!a[0]) begin
          model_mem[sel][ai]     = d[15:8];
          model_mem[sel][ai + 1] = d[7:0];
        end else bad = 1'b1;
      end
      C_STB:   model_mem[sel][ai] = d[7:0];
      default: bad = 1'b1;
    endcase
    e.mfc  = ~bad;
    e.mset = bad;
    e.dout = model_dout[sel];
    return e;
  endfunction

  task automatic drive(input int sel, input logic en, input logic [5:0] op,
                       input logic [8:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus0.RAM_enable = en; bus0.RAM_OpCode = op; bus0.Address = a; bus0.DataIn = d;
    end else begin
      bus1.RAM_enable = en; bus1.RAM_OpCode = op; bus1.Address = a; bus1.DataIn = d;
    end
  endtask

  task automatic set_en(input int sel, input logic en);
    if (sel == 0) bus0.RAM_enable = en;
    else          bus1.RAM_enable = en;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise a request at a falling edge; lat = edges until MFC/MSET seen, -1 on timeout.
  task automatic run_txn(input int sel, input logic [5:0] op, input logic [8:0] a,
                         input logic [31:0] d, output int lat);
    drive(sel, 1'b1, op, a, d);
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      cycle();
      if (rd_mfc(sel) || rd_mset(sel)) lat = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 6'h0, 9'h0, 32'h0);
    drive(1, 1'b0, 6'h0, 9'h0, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
    model_dout[0] = 32'h0;
    model_dout[1] = 32'h0;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rd_mfc(s) !== 1'b0 || rd_mset(s) !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: mfc=%b mset=%b, want 0 0", s, rd_mfc(s), rd_mset(s));
      end
      checks++;
      if (rd_dout(s) !== 32'h0) begin
        errors++;
        $display("FAIL reset_dout dut%0d: got %h want 00000000", s, rd_dout(s));
      end
    end
    checks++;
    if (u_dut0.state_q !== S_IDLE || u_dut1.state_q !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d want IDLE", u_dut0.state_q, u_dut1.state_q);
    end
  endtask

  task automatic test_word_round_trip();
    logic [5:0] ops [4]; logic [8:0] adr [4]; logic [31:0] dat [4];
    exp_t e; int lat;
    ops = '{C_ST, C_LD, C_LDUB, C_LDUB};
    adr = '{9'd32, 9'd32, 9'd35, 9'd32};
    dat = '{32'h0000_0009, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(predict(0, ops[i], adr[i], dat[i]));
      run_txn(0, ops[i], adr[i], dat[i], lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== exp_lat(0)) begin
        errors++; $display("FAIL word_lat[%0d]: got %0d want %0d", i, lat, exp_lat(0));
      end
      checks++;
      if (bus0.MFC !== e.mfc || bus0.MSET !== e.mset || bus0.DataOut !== e.dout) begin
        errors++;
        $display("FAIL word_resp[%0d]: got mfc=%b mset=%b dout=%h want mfc=%b mset=%b dout=%h",
                 i, bus0.MFC, bus0.MSET, bus0.DataOut, e.mfc, e.mset, e.dout);
      end
      set_en(0, 1'b0);
      cycle();
      checks++;
      if (bus0.MFC !== 1'b0 || bus0.MSET !== 1'b0) begin
        errors++; $display("FAIL word_release[%0d]: mfc=%b mset=%b want 0 0", i, bus0.MFC, bus0.MSET);
      end
    end
  endtask

  task automatic test_byte_half();
    logic [5:0] ops [6]; logic [8:0] adr [6]; logic [31:0] dat [6];
    exp_t e; int lat;
    ops = '{C_STB, C_STH, C_LDSB, C_LDUB, C_LDSH, C_LDUH};
    adr = '{9'd40, 9'd42, 9'd40, 9'd40, 9'd42, 9'd42};
    dat = '{32'h0000_00AB, 32'h0000_8001, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(predict(0, ops[i], adr[i], dat[i]));
      run_txn(0, ops[i], adr[i], dat[i], lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.MSET !== e.mset || bus0.DataOut !== e.dout) begin
        errors++;
        $display("FAIL byte_half[%0d]: got lat=%0d mfc=%b mset=%b dout=%h want lat=%0d mfc=%b mset=%b dout=%h",
                 i, lat, bus0.MFC, bus0.MSET, bus0.DataOut, exp_lat(0), e.mfc, e.mset, e.dout);
      end
      set_en(0, 1'b0);
      cycle();
    end
  endtask

  task automatic test_misaligned();
    logic [5:0] ops [5]; logic [8:0] adr [5]; logic [31:0] dat [5];
    exp_t e; int lat;
    ops = '{C_ST, C_LD, C_LDUH, C_LD, C_STH};
    adr = '{9'd33, 9'd32, 9'd41, 9'd34, 9'd41};
    dat = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0000_1234};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(predict(0, ops[i], adr[i], dat[i]));
      run_txn(0, ops[i], adr[i], dat[i], lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.MSET !== e.mset || bus0.DataOut !== e.dout) begin
        errors++;
        $display("FAIL misalign[%0d]: got lat=%0d mfc=%b mset=%b dout=%h want lat=%0d mfc=%b mset=%b dout=%h",
                 i, lat, bus0.MFC, bus0.MSET, bus0.DataOut, exp_lat(0), e.mfc, e.mset, e.dout);
      end
      set_en(0, 1'b0);
      cycle();
    end
  endtask

  task automatic test_handshake_hold();
    exp_t e; int lat;
    sb_q.push_back(predict(0, C_ST, 9'd44, 32'h1122_3344));
    run_txn(0, C_ST, 9'd44, 32'h1122_3344, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.MSET !== e.mset) begin
      errors++; $display("FAIL hold_st: got lat=%0d mfc=%b mset=%b want lat=%0d mfc=1 mset=0",
                         lat, bus0.MFC, bus0.MSET, exp_lat(0));
    end
    // Keep the request up with different data; nothing new may be accepted or written.
    for (int h = 0; h < 5; h++) begin
      drive(0, 1'b1, C_ST, 9'd44, 32'hA0B0_C0D0 + h);
      cycle();
      checks++;
      if (bus0.MFC !== 1'b1 || bus0.MSET !== 1'b0 || bus0.DataOut !== e.dout) begin
        errors++; $display("FAIL hold_cycle[%0d]: mfc=%b mset=%b dout=%h want 1 0 %h",
                           h, bus0.MFC, bus0.MSET, bus0.DataOut, e.dout);
      end
    end
    set_en(0, 1'b0);
    cycle();
    checks++;
    if (bus0.MFC !== 1'b0) begin
      errors++; $display("FAIL hold_drop: mfc=%b want 0", bus0.MFC);
    end
    sb_q.push_back(predict(0, C_LD, 9'd44, 32'h0));
    run_txn(0, C_LD, 9'd44, 32'h0, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.DataOut !== e.dout) begin
      errors++; $display("FAIL hold_reload: got lat=%0d mfc=%b dout=%h want lat=%0d mfc=1 dout=%h",
                         lat, bus0.MFC, bus0.DataOut, exp_lat(0), e.dout);
    end
    set_en(0, 1'b0);
    cycle();
  endtask

  task automatic test_reset_mid_op();
    exp_t e; int lat;
    sb_q.push_back(predict(0, C_ST, 9'd48, 32'hCAFE_BABE));
    run_txn(0, C_ST, 9'd48, 32'hCAFE_BABE, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.MSET !== e.mset) begin
      errors++; $display("FAIL rst_prewrite: got lat=%0d mfc=%b mset=%b want lat=%0d mfc=1 mset=0",
                         lat, bus0.MFC, bus0.MSET, exp_lat(0));
    end
    set_en(0, 1'b0);
    cycle();
    // Reset lands on the edge where the store would otherwise complete.
    drive(0, 1'b1, C_ST, 9'd48, 32'h1234_5678);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    set_en(0, 1'b0);
    rst = 1'b0;
    model_dout[0] = 32'h0;
    model_dout[1] = 32'h0;
    checks++;
    if (bus0.MFC !== 1'b0 || bus0.MSET !== 1'b0 || bus0.DataOut !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: mfc=%b mset=%b dout=%h want 0 0 00000000",
                         bus0.MFC, bus0.MSET, bus0.DataOut);
    end
    checks++;
    if (u_dut0.state_q !== S_IDLE) begin
      errors++; $display("FAIL rst_mid_state: got %0d want IDLE", u_dut0.state_q);
    end
    sb_q.push_back(predict(0, C_LD, 9'd48, 32'h0));
    run_txn(0, C_LD, 9'd48, 32'h0, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.DataOut !== e.dout) begin
      errors++; $display("FAIL rst_mid_mem: got lat=%0d mfc=%b dout=%h want lat=%0d mfc=1 dout=%h",
                         lat, bus0.MFC, bus0.DataOut, exp_lat(0), e.dout);
    end
    set_en(0, 1'b0);
    cycle();
  endtask

  task automatic test_enable_drop_busy();
    exp_t e; int lat;
    sb_q.push_back(predict(0, C_ST, 9'd60, 32'h5566_7788));
    drive(0, 1'b1, C_ST, 9'd60, 32'h5566_7788);
    cycle();
    set_en(0, 1'b0);
    lat = -1;
    for (int i = 2; i <= 40 && lat < 0; i++) begin
      cycle();
      if (bus0.MFC || bus0.MSET) lat = i;
    end
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.MFC !== e.mfc || bus0.MSET !== e.mset) begin
      errors++; $display("FAIL drop_busy: got lat=%0d mfc=%b mset=%b want lat=%0d mfc=1 mset=0",
                         lat, bus0.MFC, bus0.MSET, exp_lat(0));
    end
    cycle();
    checks++;
    if (bus0.MFC !== 1'b0 || bus0.MSET !== 1'b0) begin
      errors++; $display("FAIL drop_busy_idle: mfc=%b mset=%b want 0 0", bus0.MFC, bus0.MSET);
    end
    sb_q.push_back(predict(0, C_LD, 9'd60, 32'h0));
    run_txn(0, C_LD, 9'd60, 32'h0, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat(0) || bus0.DataOut !== e.dout) begin
      errors++; $display("FAIL drop_busy_load: got lat=%0d dout=%h want lat=%0d dout=%h",
                         lat, bus0.DataOut, exp_lat(0), e.dout);
    end
    set_en(0, 1'b0);
    cycle();
  endtask

  task automatic test_illegal_and_fast();
    int sels [5]; logic [5:0] ops [5]; logic [8:0] adr [5]; logic [31:0] dat [5];
    exp_t e; int lat;
    sels = '{0, 1, 1, 1, 1};
    ops  = '{C_BAD, C_BAD, C_ST, C_LD, C_LDSB};
    adr  = '{9'd8, 9'd8, 9'd100, 9'd100, 9'd100};
    dat  = '{32'h0, 32'h0, 32'hA5A5_0F0F, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(predict(sels[i], ops[i], adr[i], dat[i]));
      run_txn(sels[i], ops[i], adr[i], dat[i], lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== exp_lat(sels[i]) || rd_mfc(sels[i]) !== e.mfc || rd_mset(sels[i]) !== e.mset ||
          rd_dout(sels[i]) !== e.dout) begin
        errors++;
        $display("FAIL illegal_fast[%0d] dut%0d: got lat=%0d mfc=%b mset=%b dout=%h want lat=%0d mfc=%b mset=%b dout=%h",
                 i, sels[i], lat, rd_mfc(sels[i]), rd_mset(sels[i]), rd_dout(sels[i]),
                 exp_lat(sels[i]), e.mfc, e.mset, e.dout);
      end
      set_en(sels[i], 1'b0);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_word_round_trip();
    test_byte_half();
    test_misaligned();
    test_handshake_hold();
    test_reset_mid_op();
    test_enable_drop_busy();
    test_illegal_and_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
